// File: rtl/avmm_burst_read_pkg.sv
// rtl/avmm_burst_read_pkg.sv - shared states, default widths and constants for the burst read master
package avmm_burst_read_pkg;
  localparam int ADDR_W_DEF     = 15;
  localparam int DATA_W_DEF     = 32;
  localparam int LEN_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/avmm_burst_read_master_if.sv
// rtl/avmm_burst_read_master_if.sv - control, Avalon-MM and stream bundle; AVMM_BURST_READ_PERF_EN adds stall_cycles
interface avmm_burst_read_master_if
  import avmm_burst_read_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic [3:0]        m_byteenable;
  logic              m_waitrequest;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_last;
`ifdef AVMM_BURST_READ_PERF_EN
  logic [31:0]       stall_cycles;
`endif

  modport master (
    input  start, start_addr, len, m_waitrequest, m_readdata, m_readdatavalid, st_ready,
`ifdef AVMM_BURST_READ_PERF_EN
    output stall_cycles,
`endif
    output busy, done, m_address, m_read, m_byteenable, st_data, st_valid, st_last
  );

  modport slave (
    output start, start_addr, len, m_waitrequest, m_readdata, m_readdatavalid, st_ready,
`ifdef AVMM_BURST_READ_PERF_EN
    input  stall_cycles,
`endif
    input  busy, done, m_address, m_read, m_byteenable, st_data, st_valid, st_last
  );
endinterface

// File: rtl/avmm_burst_read_fifo.sv
// rtl/avmm_burst_read_fifo.sv - first-word-fall-through response buffer with occupancy count
module avmm_burst_read_fifo
  import avmm_burst_read_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  localparam int CW    = cnt_w(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/avmm_burst_read_master.sv
// rtl/avmm_burst_read_master.sv - Avalon-MM pipelined block reader feeding an Avalon-ST source
// Optional AVMM_BURST_READ_PERF_EN adds the stall_cycles counter on the interface.
module avmm_burst_read_master
  import avmm_burst_read_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic clk,
  input logic reset_n,
  avmm_burst_read_master_if.master bus
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int UW = CW + 1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_m_read;
  logic              r_busy;
  logic              r_done;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_delivered;
  logic [CW-1:0]     r_outstanding;

  logic              w_accept;
  logic              w_resp;
  logic              w_pop;
  logic              w_st_valid;
  logic              w_fifo_empty;
  logic              w_can_issue;
  logic [CW-1:0]     w_fifo_count;
  logic [CW-1:0]     w_out_nx;
  logic [CW-1:0]     w_cnt_nx;
  logic [UW-1:0]     w_used_nx;
  logic [LEN_W-1:0]  w_issued_nx;
  logic [LEN_W-1:0]  w_delivered_nx;
  logic [DATA_W-1:0] w_st_data;

  assign w_accept       = r_m_read && !bus.m_waitrequest;
  assign w_resp         = bus.m_readdatavalid && (r_state == ISSUE || r_state == DRAIN);
  assign w_st_valid     = !w_fifo_empty;
  assign w_pop          = w_st_valid && bus.st_ready;
  assign w_issued_nx    = r_issued + LEN_W'(w_accept);
  assign w_delivered_nx = r_delivered + LEN_W'(w_pop);
  assign w_out_nx       = r_outstanding + CW'(w_accept) - CW'(w_resp);
  assign w_cnt_nx       = w_fifo_count + CW'(w_resp) - CW'(w_pop);
  // m_read is registered, so credit is judged on the post-edge buffer plus in-flight totals.
  assign w_used_nx      = {1'b0, w_out_nx} + {1'b0, w_cnt_nx};
  assign w_can_issue    = (w_issued_nx < r_len) && (w_used_nx < UW'(FIFO_DEPTH));

  avmm_burst_read_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_resp),
    .i_data  (bus.m_readdata),
    .i_pop   (w_pop),
    .o_data  (w_st_data),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_m_read      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_len         <= '0;
      r_issued      <= '0;
      r_delivered   <= '0;
      r_outstanding <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_addr        <= bus.start_addr;
            r_len         <= bus.len;
            r_issued      <= '0;
            r_delivered   <= '0;
            r_outstanding <= '0;
            if (bus.len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ISSUE;
              r_busy  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          r_issued      <= w_issued_nx;
          r_delivered   <= w_delivered_nx;
          r_outstanding <= w_out_nx;
          if (w_accept) r_addr <= r_addr + ADDR_W'(1);
          if (w_issued_nx == r_len) begin
            r_state  <= DRAIN;
            r_m_read <= 1'b0;
          end else begin
            r_m_read <= (r_m_read && bus.m_waitrequest) || w_can_issue;
          end
        end
        DRAIN: begin
          r_delivered   <= w_delivered_nx;
          r_outstanding <= w_out_nx;
          if (w_delivered_nx == r_len) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AVMM_BURST_READ_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
    end else if (r_state == IDLE && bus.start) begin
      r_stall_cycles <= '0;
    end else if (r_busy && ((r_m_read && bus.m_waitrequest) || (w_st_valid && !bus.st_ready))
                 && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`endif

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.m_address    = r_addr;
  assign bus.m_read       = r_m_read;
  assign bus.m_byteenable = BE_ALL;
  assign bus.st_data      = w_st_data;
  assign bus.st_valid     = w_st_valid;
  assign bus.st_last      = w_st_valid && (r_delivered == r_len - LEN_W'(1));
endmodule
